// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Build option: define MULDIV_EARLY_OUT_EN to end multiplies once the remaining multiplier bits are zero.
module muldiv_sequencer #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [RD_W-1:0] rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] rd_out
);

  // state | meaning
  // IDLE  | waiting for a request, in_ready high
  // CALC  | one shift/add (multiply) or shift/subtract (divide) step per cycle
  // FIXUP | sign correction and result select
  // DONE  | result held until writeback takes it
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state;
  logic [2:0]        op;
  logic              neg_a;
  logic              neg_b;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;    // product, or {remainder, dividend shifting into quotient}
  logic [2*XLEN-1:0] mcand;  // shifted multiplicand, or divisor in the low half
  logic [XLEN-1:0]   mplier;

  logic              sgn_a, sgn_b, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_in = sgn_a & rs1[XLEN-1];
    b_neg_in = sgn_b & rs2[XLEN-1];
    a_mag    = a_neg_in ? -rs1 : rs1;
    b_mag    = b_neg_in ? -rs2 : rs2;
    div_zero = (rs2 == '0);
    div_ovf  = ~funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
    special  = funct3[2] && (div_zero || div_ovf);
    if (div_zero)
      special_res = funct3[1] ? rs1 : '1;
    else
      special_res = funct3[1] ? '0 : MIN_NEG;
  end

  logic [XLEN:0]     rem_trial, rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] acc_div_next, acc_mul_next;

  always_comb begin
    rem_trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    rem_diff     = rem_trial - {1'b0, mcand[XLEN-1:0]};
    q_bit        = (rem_trial >= {1'b0, mcand[XLEN-1:0]});
    rem_next     = q_bit ? rem_diff[XLEN-1:0] : rem_trial[XLEN-1:0];
    acc_div_next = {rem_next, acc[XLEN-2:0], q_bit};
    acc_mul_next = acc + (mplier[0] ? mcand : '0);
  end

  logic early_stop, accept_skip;
`ifdef MULDIV_EARLY_OUT_EN
  assign early_stop  = ~op[2] && (mplier[XLEN-1:1] == '0);
  assign accept_skip = ~funct3[2] && (b_mag == '0);
`else
  assign early_stop  = 1'b0;
  assign accept_skip = 1'b0;
`endif

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? -acc : acc;
    quo_fix  = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else if (flush && state != IDLE) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            op     <= funct3;
            rd_out <= rd_in;
            neg_a  <= a_neg_in;
            neg_b  <= b_neg_in;
            cnt    <= '0;
            if (special) begin
              result    <= special_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              if (funct3[2]) begin
                acc    <= {{XLEN{1'b0}}, a_mag};
                mcand  <= {{XLEN{1'b0}}, b_mag};
                mplier <= '0;
              end else begin
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, a_mag};
                mplier <= b_mag;
              end
              state <= accept_skip ? FIXUP : CALC;
            end
          end
        end
        CALC: begin
          if (op[2]) begin
            acc <= acc_div_next;
          end else begin
            acc    <= acc_mul_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST || early_stop)
            state <= FIXUP;
        end
        FIXUP: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected result, tag and latency queued at issue, checked at out_valid.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1, rs2, result;
  logic [RD_W-1:0] rd_in, rd_out;
  logic            flush, busy, out_valid, out_ready;

  muldiv_sequencer #(.XLEN(XLEN), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .flush(flush),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sbv;
    sa  = a;
    sbv = b;
    p   = '0;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'(sa) * longint'(sbv); return p[63:32]; end
      3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
        return sa / sbv;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges from the accept edge to the edge where out_valid is first sampled high.
  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag;
    int k;
    if (f3[2] && (b == 0 || (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
    mag = (f3 == 3'b001 && b[31]) ? -b : b;
    k = 0;
    for (int i = 0; i < 32; i++)
      if (mag[i]) k = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f3[2]) return k + 2;
`endif
    return (k >= 0) ? 34 : 0;
  endfunction

  // Called at #1 after an edge; returns at #1 after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp_res, input bit push);
    exp_t e;
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("issue_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd_in = rd;
    if (push) begin
      e.res = exp_res; e.rd = rd; e.lat = exp_lat(f3, a, b);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int hold);
    exp_t e;
    int n;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    out_ready = (hold == 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n + 1, e.lat);
    check({tag, "_res"}, result, e.res);
    check({tag, "_rd"}, 32'(rd_out), 32'(e.rd));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_ov"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_res"}, result, e.res);
      check({tag, "_hold_rd"}, 32'(rd_out), 32'(e.rd));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    bit          saw;
    int          n;

    rst_n = 1'b0; in_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    rd_in = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(3'd0, 32'd7, 32'd6, 5'd3, 32'd42, 1);                          collect("mul", 0);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1);   collect("mulh", 0);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 1);   collect("mulhsu", 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, 1);   collect("mulhu", 0);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 1);           collect("div", 0);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 1);           collect("rem", 0);
    issue(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 1);                        collect("divu", 0);
    issue(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 1);                        collect("remu", 0);
    issue(3'd5, 32'd1234, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);               collect("divu_zero", 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);          collect("rem_ovf", 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);  collect("div_ovf", 0);
    issue(3'd7, 32'd77, 32'd0, 5'd14, 32'd77, 1);                        collect("remu_zero", 0);

    // flush in CALC
    issue(3'd4, 32'd1000, 32'd3, 5'd15, 32'd0, 0);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("flush_no_out_valid", 32'(saw), 32'd0);
    issue(3'd0, 32'd3, 32'd5, 5'd16, 32'd15, 1);                         collect("mul_after_flush", 0);

    // flush blocks acceptance in IDLE
    in_valid = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd2; rs2 = 32'd2; rd_in = 5'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("idle_flush_in_ready", 32'(in_ready), 32'd1);
    check("idle_flush_busy", 32'(busy), 32'd0);

    // flush beats out_ready in DONE
    out_ready = 1'b0;
    issue(3'd0, 32'd9, 32'd9, 5'd17, 32'd0, 0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_flush_reached", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("done_flush_ov", 32'(out_valid), 32'd0);
    check("done_flush_in_ready", 32'(in_ready), 32'd1);

    issue(3'd5, 32'd100, 32'd7, 5'd18, 32'd14, 1);                       collect("backpressure", 5);
    issue(3'd0, 32'd123, 32'd1, 5'd19, 32'd123, 1);                      collect("mul_by_one", 0);
    issue(3'd0, 32'd123, 32'd0, 5'd20, 32'd0, 1);                        collect("mul_by_zero", 0);
    issue(3'd1, 32'd5, 32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFF, 1);          collect("mulh_neg_b", 0);

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      rd = 5'($urandom);
      issue(f3, a, b, rd, model(f3, a, b), 1);
      collect("rand", 0);
    end

    // reset mid-operation
    issue(3'd0, 32'd11, 32'd13, 5'd22, 32'd0, 0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd_out", 32'(rd_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd7, 32'd50, 32'd8, 5'd23, 32'd2, 1);                         collect("remu_after_rst", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative radix-2 sequencer for the RV32M multiply and divide instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in EX beside the single-cycle ALU. The main decoder routes funct7=0000001 R-type ops here instead of to the ALU.
- Owns the multi-cycle shift/add/subtract datapath and drives the busy signal the hazard unit uses to stall the pipeline.
- Accepts one operation at a time and returns the result with its destination-register tag.

Parameters:
- XLEN, 32, operand and result width.
- RD_W, 5, destination-register tag width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- funct3  in  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A (multiplicand or dividend).
- rs2  in  XLEN  operand B (multiplier or divisor).
- rd_in  in  RD_W  destination tag.
- flush  in  1  abort the current operation (branch mispredict or trap).
- busy  out  1  high in CALC, FIXUP and DONE.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts the result.
- result  out  XLEN  result data.
- rd_out  out  RD_W  captured destination tag.

Behaviour:
- Reset: state=IDLE; in_ready=1; busy=0; out_valid=0; result=0; rd_out=0; all internal registers=0.
- Accept: in_valid & in_ready at an edge latches funct3, rd_in, and the operand magnitudes plus sign flags.
  - Signed operands: DIV, REM, MULH, and rs1 of MULHSU.
- States:
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept when a special case applies.
  - CALC runs exactly XLEN cycles, counter 0..XLEN-1; CALC -> FIXUP when counter=XLEN-1.
  - FIXUP -> DONE after 1 cycle.
  - DONE -> IDLE when out_ready is high.
- Multiply: shift-add over a 2*XLEN product register, one multiplier bit per cycle, LSB first.
  - FIXUP negates the product when sign(A) xor sign(B).
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring division, one quotient bit per cycle, MSB first.
  - FIXUP negates the quotient when the operand signs differ, and negates the remainder when the dividend is negative.
- Special cases, handled with no CALC cycles:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Latency, counted from the accept edge:
  - Normal case: out_valid rises XLEN+2 edges later (34 edges).
  - Special case: out_valid rises 1 edge later.
- Output holding: while out_valid=1, out_valid, result and rd_out hold stable until the out_ready edge. out_valid drops on that edge.
- in_ready is low in DONE. A new request is accepted no earlier than the cycle after the handshake.
- flush:
  - In any state other than IDLE: next state IDLE, out_valid=0, and the result is discarded (no writeback).
  - In IDLE it blocks acceptance; flush overrides in_valid in the same cycle.
  - flush and out_ready high together in DONE: flush wins, and the result is dropped.
- rst_n low mid-operation: immediate return to reset values, no partial result visible.
- result is registered and is never driven combinationally from inputs.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: in multiply ops, CALC -> FIXUP as soon as the remaining unshifted multiplier bits are all zero, checked after each step.
  - Normal-case latency becomes k+2 edges, where k = position of the highest set bit of |B| plus 1.
  - A zero multiplier has k=0 (CALC skipped): FIXUP follows directly, so out_valid rises 2 edges after accept.
  - Divide latency and all results are unchanged.
- Undefined: fixed XLEN CALC cycles for every non-special op.

Test Plan:
- MUL rs1=7, rs2=6, rd_in=3, out_ready=1 -> out_valid 34 edges after accept, result=42, rd_out=3, in_ready high the following cycle.
- MULH rs1=0x80000000, rs2=0x80000000 -> result=0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> result=0xFFFFFFFF. MULHU with the same operands -> result=0xFFFFFFFE.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> result=0xFFFFFFFD. REM with the same operands -> result=0xFFFFFFFF. DIVU rs1=100, rs2=7 -> 14. REMU -> 2.
- DIVU rs2=0 -> result=0xFFFFFFFF 1 edge after accept. REM rs1=0x80000000, rs2=0xFFFFFFFF -> result=0, latency 1.
- DIV started, flush asserted at CALC cycle 10 -> IDLE next edge, out_valid never rises, next MUL 3*5 returns 15.
- Backpressure: out_ready held low for 5 cycles after out_valid -> result/rd_out stable, in_ready=0, busy=1. Then out_ready=1 -> out_valid=0 next edge. With MULDIV_EARLY_OUT_EN defined: MUL by rs2=1 -> out_valid 3 edges after accept.
